// File: rtl/ps2_command_transmitter_if.sv
`default_nettype none
// ============================================================================
// ps2_command_transmitter_if : command request / status handshake bundle
// Rev 1.0
// ============================================================================
interface ps2_command_transmitter_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic       error_no_ack;

  modport master (
    output the_command, send_command,
    input  busy, command_was_sent, error_communication_timed_out, error_no_ack
  );

  modport slave (
    input  the_command, send_command,
    output busy, command_was_sent, error_communication_timed_out, error_no_ack
  );
endinterface
`default_nettype wire

// File: rtl/ps2_command_transmitter.sv
`default_nettype none
// ============================================================================
// ps2_command_transmitter : host-to-device PS/2 byte sender with ACK check
// Rev 1.0
// ============================================================================
module ps2_command_transmitter #(
  parameter int CLOCK_FREQUENCY      = 50000000,
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  wire logic                CLOCK_50,
  input  wire logic                reset,
  ps2_command_transmitter_if.slave cmd,
  inout  wire                      PS2_CLK,
  inout  wire                      PS2_DAT
);

  localparam int MAX_A  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_TO = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;

  if (CLOCK_FREQUENCY < 1 || INHIBIT_CYCLES < 1 || START_TIMEOUT_CYCLES < 1 || XFER_TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_command_transmitter: all timing parameters must be positive");
  end

  typedef enum logic [3:0] {
    IDLE, INHIBIT, REQUEST, WAIT_START, SEND, ACK, WAIT_IDLE_OK, WAIT_IDLE_NAK, ERR_TO
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             clk_low_q, clk_low_d;
  logic             dat_low_q, dat_low_d;
  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  logic             busy_q, busy_d;
  logic             sent_q, sent_d;
  logic             timeout_q, timeout_d;
  logic             no_ack_q, no_ack_d;

  logic fe;
  logic xfer_expired;
  logic lines_idle;

  assign fe           = clk_prev_q & ~clk_sync_q[1];
  assign xfer_expired = (cnt_q == CNT_W'(XFER_TIMEOUT_CYCLES - 1));
  assign lines_idle   = clk_sync_q[1] & dat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    sent_d    = 1'b0;
    timeout_d = 1'b0;
    no_ack_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.send_command) begin
          state_d  = INHIBIT;
          cnt_d    = '0;
          shift_d  = cmd.the_command;
          parity_d = ~^cmd.the_command;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d = REQUEST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQUEST: begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      WAIT_START: begin
        if (fe) begin
          state_d   = SEND;
          cnt_d     = '0;
          bit_idx_d = 4'd0;
        end else if (cnt_q == CNT_W'(START_TIMEOUT_CYCLES - 1)) begin
          state_d = ERR_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (xfer_expired) begin
          state_d = ERR_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fe) begin
            bit_idx_d = (bit_idx_q == 4'd11) ? 4'd11 : bit_idx_q + 4'd1;
            // Index 9 is the stop bit: DAT is released and the device drives ACK next.
            if (bit_idx_q == 4'd8) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (xfer_expired) begin
          state_d = ERR_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fe) begin
            bit_idx_d = (bit_idx_q == 4'd11) ? 4'd11 : bit_idx_q + 4'd1;
            state_d   = dat_sync_q[1] ? WAIT_IDLE_NAK : WAIT_IDLE_OK;
          end
        end
      end
      WAIT_IDLE_OK, WAIT_IDLE_NAK: begin
        if (xfer_expired) begin
          state_d = ERR_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (lines_idle) begin
            state_d  = IDLE;
            sent_d   = (state_q == WAIT_IDLE_OK);
            no_ack_d = (state_q == WAIT_IDLE_NAK);
          end
        end
      end
      ERR_TO: begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Line drives are decoded from the next state so they change with it.
    clk_low_d = (state_d == INHIBIT) || (state_d == REQUEST);
    dat_low_d = 1'b0;
    case (state_d)
      REQUEST, WAIT_START: dat_low_d = 1'b1;
      SEND: begin
        if (bit_idx_d < 4'd8)       dat_low_d = ~shift_q[bit_idx_d[2:0]];
        else if (bit_idx_d == 4'd8) dat_low_d = ~parity_q;
        else                        dat_low_d = 1'b0;
      end
      default: dat_low_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      timeout_q  <= 1'b0;
      no_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      timeout_q  <= timeout_d;
      no_ack_q   <= no_ack_d;
    end
  end

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign cmd.busy                          = busy_q;
  assign cmd.command_was_sent              = sent_q;
  assign cmd.error_communication_timed_out = timeout_q;
  assign cmd.error_no_ack                  = no_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_transmitter.sv
`default_nettype none
// ============================================================================
// tb_ps2_command_transmitter : device BFM + status scoreboard bench
// Rev 1.0
// ============================================================================
module tb_ps2_command_transmitter;
  localparam int INH = 200;
  localparam int STO = 1500;
  localparam int XTO = 3000;
  localparam int H   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  wire ps2_clk;
  wire ps2_dat;
  pullup (ps2_clk);
  pullup (ps2_dat);
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_command_transmitter_if cmd_if ();

  ps2_command_transmitter #(
    .CLOCK_FREQUENCY     (50000000),
    .INHIBIT_CYCLES      (INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES (XTO)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .cmd     (cmd_if),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat)
  );

  int tests = 0;
  int fails = 0;
  // status code {timeout, no_ack, sent}; frame entry {parity, data}
  logic [2:0] exp_status [$];
  logic [8:0] exp_frame  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every status pulse must match the oldest expectation.
  initial begin
    logic [2:0] code;
    forever begin
      @(negedge clk);
      code = {cmd_if.error_communication_timed_out, cmd_if.error_no_ack, cmd_if.command_was_sent};
      if (code != 3'b000) begin
        if (exp_status.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_status: got %b, expected no pulse", code);
        end else begin
          check("status_code", {29'd0, code}, {29'd0, exp_status.pop_front()});
        end
        check("busy_with_pulse", {31'd0, cmd_if.busy}, 32'd0);
      end
    end
  end

  task automatic device_frame(input bit do_ack, input int abort_after);
    logic [9:0] bits;
    logic [8:0] exp;
    bit found;
    bits  = '0;
    found = 1'b0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("request_seen", {31'd0, found}, 32'd1);
    if (!found) return;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bits[i] = ps2_dat;
      dev_clk_low = 1'b0;
      if (i == abort_after) return;
      repeat (H) @(negedge clk);
    end
    if (do_ack) dev_dat_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_dat_low = 1'b0;
    if (exp_frame.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_frame: got 0x%0h, expected none", bits);
    end else begin
      exp = exp_frame.pop_front();
      check("frame_data",   {24'd0, bits[7:0]}, {24'd0, exp[7:0]});
      check("frame_parity", {31'd0, bits[8]},   {31'd0, exp[8]});
      check("frame_stop",   {31'd0, bits[9]},   32'd1);
    end
  endtask

  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    cmd_if.the_command  = b;
    cmd_if.send_command = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.send_command = 1'b0;
    check("accept_busy",    {31'd0, cmd_if.busy}, 32'd1);
    check("accept_clk_low", {31'd0, ps2_clk},     32'd0);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < XTO + STO + INH; i++) begin
      @(negedge clk);
      if (!cmd_if.busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic acked_send(input logic [7:0] b, input logic parity, input string name);
    exp_frame.push_back({parity, b});
    exp_status.push_back(3'b001);
    issue(b);
    device_frame(1'b1, -1);
    wait_idle(name);
  endtask

  initial begin
    int lo;
    logic dat_last, dat_prev;
    int t0;
    bit seen;

    cmd_if.the_command  = 8'h00;
    cmd_if.send_command = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, cmd_if.busy}, 32'd0);
    check("rst_pulses",  {29'd0, cmd_if.error_communication_timed_out, cmd_if.error_no_ack, cmd_if.command_was_sent}, 32'd0);
    check("rst_clk_rel", {31'd0, ps2_clk}, 32'd1);
    check("rst_dat_rel", {31'd0, ps2_dat}, 32'd1);
    // send_command coincident with reset must be ignored
    cmd_if.the_command  = 8'h5A;
    cmd_if.send_command = 1'b1;
    @(negedge clk);
    cmd_if.send_command = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("send_during_rst_ignored", {31'd0, cmd_if.busy}, 32'd0);

    // 0xED: 1,0,1,1,0,1,1,1 LSB first, parity 1; CLK low exactly INH+1 cycles
    exp_frame.push_back({1'b1, 8'hED});
    exp_status.push_back(3'b001);
    issue(8'hED);
    fork
      device_frame(1'b1, -1);
      begin
        lo = 0;
        dat_last = 1'b1;
        dat_prev = 1'b1;
        for (int i = 0; i < INH + 50; i++) begin
          @(negedge clk);
          if (ps2_clk !== 1'b0) break;
          lo++;
          dat_prev = dat_last;
          dat_last = ps2_dat;
        end
        check("clk_low_cycles",     lo, INH + 1);
        check("dat_low_before_rel", {31'd0, dat_last}, 32'd0);
        check("dat_high_in_inhibit", {31'd0, dat_prev}, 32'd1);
      end
    join
    wait_idle("idle_ed");

    acked_send(8'h00, 1'b1, "idle_00");
    acked_send(8'h01, 1'b0, "idle_01");
    acked_send(8'hFF, 1'b1, "idle_ff");

    // silent device: start timeout
    exp_status.push_back(3'b100);
    issue(8'h55);
    seen = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_clk_released", {31'd0, seen}, 32'd1);
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < STO + 50; i++) begin
      @(negedge clk);
      if (cmd_if.error_communication_timed_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_pulse_seen", {31'd0, seen}, 32'd1);
    check("to_window", {31'd0, ((cyc - t0) >= STO) && ((cyc - t0) <= STO + 2)}, 32'd1);
    check("to_lines_rel", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("to_busy", {31'd0, cmd_if.busy}, 32'd0);
    repeat (3) @(negedge clk);

    // NAK: 0xA5 has four ones -> parity 1
    exp_frame.push_back({1'b1, 8'hA5});
    exp_status.push_back(3'b010);
    issue(8'hA5);
    device_frame(1'b0, -1);
    wait_idle("idle_nak");

    // reset after 4th data bit of 0x00 (DAT driving bit3 = 0)
    issue(8'h00);
    device_frame(1'b1, 3);
    check("mid_dat_driven", {31'd0, ps2_dat}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_lines_rel", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("mid_rst_busy", {31'd0, cmd_if.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // 0xF4 has five ones -> parity 0
    acked_send(8'hF4, 1'b0, "idle_f4");

    // send_command while busy is ignored: 0x12 (two ones -> parity 1)
    exp_frame.push_back({1'b1, 8'h12});
    exp_status.push_back(3'b001);
    issue(8'h12);
    fork
      device_frame(1'b1, -1);
      begin
        repeat (INH + 60) @(negedge clk);
        cmd_if.the_command  = 8'hAA;
        cmd_if.send_command = 1'b1;
        @(negedge clk);
        cmd_if.send_command = 1'b0;
        check("busy_during_ignore", {31'd0, cmd_if.busy}, 32'd1);
      end
    join
    wait_idle("idle_12");
    repeat (INH + 20) @(negedge clk);
    check("no_second_transfer", {31'd0, cmd_if.busy}, 32'd0);

    check("status_queue_empty", exp_status.size(), 0);
    check("frame_queue_empty",  exp_frame.size(),  0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
